// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential radix-2 restoring unsigned divider, one quotient bit per clock
module shift_sub_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] q_q, r_q, d_q, diff_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   trial_d;
  logic             ge_d, busy_q, done_q, dbz_q;
  // trial keeps the shifted-out remainder MSB, so divisors up to 2^WIDTH-1 compare correctly
  always_comb begin
    trial_d = {r_q, q_q[WIDTH-1]};
    ge_d    = trial_d >= {1'b0, d_q};
    diff_d  = trial_d[WIDTH-1:0] - d_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (start && state_q != RUN) begin
      state_q <= RUN;
      d_q     <= divisor;
      q_q     <= dividend;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (state_q == RUN) begin
      if (d_q == '0) begin
        state_q <= FIN;
        q_q     <= '1;
        r_q     <= q_q;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        dbz_q   <= 1'b1;
      end else begin
        r_q   <= ge_d ? diff_d : trial_d[WIDTH-1:0];
        q_q   <= {q_q[WIDTH-2:0], ge_d};
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_q <= FIN;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
      end
    end
  end
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
endmodule
